// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing / test-pattern block.
//   pat_e        pattern encodings carried by mode_sel / mode_cur
//   BAR_TABLE    colour-bar palette, {R,G,B} on/off bits, index 0 = leftmost bar
//   pipe_ctl_t   control payload travelling alongside each pixel in the pipe
//   line_total   helper to derive H_TOTAL / V_TOTAL from the four segments
package video_timing_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned FCNT_W  = 16;

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_CHECK  = 2'd1,
    PAT_SCROLL = 2'd2,
    PAT_GRAD   = 2'd3
  } pat_e;

  // Entry 7 is the top slice: black, blue, red, magenta, green, cyan, yellow, white.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef struct packed {
    logic              de;
    logic              hs;
    logic              vs;
    logic              fs;
    pat_e              mode;
    logic [FCNT_W-1:0] fcnt;
  } pipe_ctl_t;

  function automatic int unsigned line_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Horizontal/vertical raster counters with enable hold.
// Ports:
//   clk_i, reset_i    pixel clock, synchronous active-high reset
//   enable_i          1 = advance counters, 0 = hold and report blanking
//   h_cnt_o, v_cnt_o  registered raster position
//   wrap_c_o          last pixel of the frame is current and enabled
//   de_c_o            position is inside the visible area (enabled)
//   hs_c_o, vs_c_o    position is inside the sync window (active-high sense)
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  output logic [COORD_W-1:0] h_cnt_o,
  output logic [COORD_W-1:0] v_cnt_o,
  output logic               wrap_c_o,
  output logic               de_c_o,
  output logic               hs_c_o,
  output logic               vs_c_o
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic               h_last;
  logic               v_last;

  assign h_last = (h_q == COORD_W'(H_TOTAL - 1));
  assign v_last = (v_q == COORD_W'(V_TOTAL - 1));

  // Next raster position; frozen while disabled.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (enable_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + COORD_W'(1);
      end else begin
        h_d = h_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Raw decode; all of it reads as blanking while the raster is frozen.
  assign wrap_c_o = enable_i & h_last & v_last;
  assign de_c_o   = enable_i & (h_q < COORD_W'(H_ACTIVE)) & (v_q < COORD_W'(V_ACTIVE));
  assign hs_c_o   = enable_i & (h_q >= COORD_W'(HS_BEG)) & (h_q < COORD_W'(HS_END));
  assign vs_c_o   = enable_i & (v_q >= COORD_W'(VS_BEG)) & (v_q < COORD_W'(VS_END));

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;

endmodule

// File: rtl/video_pattern_timing_gen.sv
// Video timing generator with runtime-selectable test patterns.
// Ports:
//   clk_dot        pixel clock
//   reset          synchronous, active-high
//   enable         1 = run, 0 = freeze raster and blank outputs
//   mode_sel       requested pattern, taken at the frame boundary
//   vga_active     data enable
//   vga_hsync      hsync, active level HS_POL
//   vga_vsync      vsync, active level VS_POL
//   vga_pixel_rgb  {R,G,B}, COLOR_BITS each, zero outside the visible area
//   frame_start    one-cycle pulse with the first visible pixel of a frame
//   mode_cur       pattern shown on the current output pixel
//   frame_cnt      frames completed, aligned with the current output pixel
// Pipeline: counters -> stage1 (pattern compute) -> stage2 (outputs); every
// output is two clocks behind the counter value it describes.
module video_pattern_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter int unsigned HS_POL     = 1,
  parameter int unsigned VS_POL     = 1,
  parameter int unsigned COLOR_BITS = 8
) (
  input  logic                    clk_dot,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode_sel,
  output logic                    vga_active,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [3*COLOR_BITS-1:0] vga_pixel_rgb,
  output logic                    frame_start,
  output logic [1:0]              mode_cur,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned RGB_W  = 3 * COLOR_BITS;
  localparam int unsigned BAR_W  = H_ACTIVE / 8;
  localparam logic        HS_ACT = 1'(HS_POL);
  localparam logic        VS_ACT = 1'(VS_POL);

  localparam pipe_ctl_t CTL_IDLE = '{
    de:   1'b0,
    hs:   ~HS_ACT,
    vs:   ~VS_ACT,
    fs:   1'b0,
    mode: PAT_BARS,
    fcnt: '0
  };

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               wrap_c;
  logic               de_c;
  logic               hs_c;
  logic               vs_c;

  pat_e               mode_q, mode_d;
  logic [COORD_W-1:0] scroll_q, scroll_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  pipe_ctl_t          s1_ctl_q, s1_ctl_d;
  logic [RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
  pipe_ctl_t          s2_ctl_q;
  logic [RGB_W-1:0]   s2_rgb_q;

  logic [2:0]         bar_idx;
  logic [2:0]         bar_rgb;
  logic [7:0]         x8;
  logic [7:0]         y8;
  logic [7:0]         r8, g8, b8;

  video_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .clk_i    (clk_dot),
    .reset_i  (reset),
    .enable_i (enable),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .wrap_c_o (wrap_c),
    .de_c_o   (de_c),
    .hs_c_o   (hs_c),
    .vs_c_o   (vs_c)
  );

  // Keep the top COLOR_BITS of an 8-bit channel value.
  function automatic logic [COLOR_BITS-1:0] chan_trunc(input logic [7:0] v);
    return COLOR_BITS'(v >> (8 - COLOR_BITS));
  endfunction

  // Frame-boundary state: pattern latch, frame counter, scroll column.
  always_comb begin
    mode_d   = mode_q;
    scroll_d = scroll_q;
    fcnt_d   = fcnt_q;
    if (wrap_c) begin
      mode_d   = pat_e'(mode_sel);
      fcnt_d   = fcnt_q + FCNT_W'(1);
      scroll_d = (scroll_q == COORD_W'(H_ACTIVE - 1)) ? '0 : scroll_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      mode_q   <= PAT_BARS;
      scroll_q <= '0;
      fcnt_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      scroll_q <= scroll_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Bar index from a ladder of constant comparators instead of a divide.
  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_cnt >= COORD_W'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  assign bar_rgb = BAR_TABLE[bar_idx];
  assign x8      = h_cnt[7:0];
  assign y8      = v_cnt[7:0];

  // Stage 1: 8-bit channel values for the selected pattern.
  always_comb begin
    r8 = 8'h00;
    g8 = 8'h00;
    b8 = 8'h00;
    case (mode_q)
      PAT_BARS: begin
        r8 = {8{bar_rgb[2]}};
        g8 = {8{bar_rgb[1]}};
        b8 = {8{bar_rgb[0]}};
      end
      PAT_CHECK: begin
        r8 = {8{x8[5] ^ y8[5]}};
        g8 = r8;
        b8 = r8;
      end
      PAT_SCROLL: begin
        r8 = {8{(h_cnt == scroll_q) | (v_cnt == '0) |
                (v_cnt == COORD_W'(V_ACTIVE - 1))}};
        g8 = r8;
        b8 = r8;
      end
      PAT_GRAD: begin
        r8 = x8;
        g8 = y8;
        b8 = fcnt_q[7:0];
      end
    endcase
  end

  // Stage 1 payload; mode/frame count travel with the pixel they produced.
  always_comb begin
    s1_ctl_d      = CTL_IDLE;
    s1_ctl_d.de   = de_c;
    s1_ctl_d.hs   = hs_c ? HS_ACT : ~HS_ACT;
    s1_ctl_d.vs   = vs_c ? VS_ACT : ~VS_ACT;
    s1_ctl_d.fs   = de_c & (h_cnt == '0) & (v_cnt == '0);
    s1_ctl_d.mode = mode_q;
    s1_ctl_d.fcnt = fcnt_q;
    s1_rgb_d      = de_c ? {chan_trunc(r8), chan_trunc(g8), chan_trunc(b8)} : '0;
  end

  // Stage 1 and stage 2 registers.
  always_ff @(posedge clk_dot) begin
    if (reset) begin
      s1_ctl_q <= CTL_IDLE;
      s1_rgb_q <= '0;
      s2_ctl_q <= CTL_IDLE;
      s2_rgb_q <= '0;
    end else begin
      s1_ctl_q <= s1_ctl_d;
      s1_rgb_q <= s1_rgb_d;
      s2_ctl_q <= s1_ctl_q;
      s2_rgb_q <= s1_rgb_q;
    end
  end

  assign vga_active    = s2_ctl_q.de;
  assign vga_hsync     = s2_ctl_q.hs;
  assign vga_vsync     = s2_ctl_q.vs;
  assign frame_start   = s2_ctl_q.fs;
  assign mode_cur      = s2_ctl_q.mode;
  assign frame_cnt     = s2_ctl_q.fcnt;
  assign vga_pixel_rgb = s2_rgb_q;

endmodule

// File: tb/tb_video_pattern_timing_gen.sv
// Scoreboard bench: a cycle model pushes the expected output for each clock
// and the entry is popped once the two-stage pipe should have produced it.
// Two instances share stimulus; the second is built with inverted sync polarity.
module tb_video_pattern_timing_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 8, VF = 1, VSW = 2, VB = 1;
  localparam int CB = 4;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  typedef logic [33:0] vec_t;

  logic        clk_dot = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode_sel;

  logic        a_de, a_hs, a_vs, a_fs;
  logic [11:0] a_rgb;
  logic [1:0]  a_mode;
  logic [15:0] a_fcnt;
  logic        n_de, n_hs, n_vs, n_fs;
  logic [11:0] n_rgb;
  logic [1:0]  n_mode;
  logic [15:0] n_fcnt;

  always #5 clk_dot = ~clk_dot;

  video_pattern_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .COLOR_BITS(CB)
  ) dut (
    .clk_dot(clk_dot), .reset(reset), .enable(enable), .mode_sel(mode_sel),
    .vga_active(a_de), .vga_hsync(a_hs), .vga_vsync(a_vs),
    .vga_pixel_rgb(a_rgb), .frame_start(a_fs), .mode_cur(a_mode), .frame_cnt(a_fcnt)
  );

  video_pattern_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .COLOR_BITS(CB)
  ) dut_n (
    .clk_dot(clk_dot), .reset(reset), .enable(enable), .mode_sel(mode_sel),
    .vga_active(n_de), .vga_hsync(n_hs), .vga_vsync(n_vs),
    .vga_pixel_rgb(n_rgb), .frame_start(n_fs), .mode_cur(n_mode), .frame_cnt(n_fcnt)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];

  // Model state: counter position and frame-boundary registers.
  int m_h = 0, m_v = 0, m_mode = 0, m_scroll = 0, m_fcnt = 0;

  // Output observer used for the scroll-line tracking.
  int obs_row = 0, obs_col = 0;
  int scroll_on = 0, col_seen = -1, prev_col = -1, wraps = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int b);
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb();
    case (m_mode)
      0: return bar_colour(m_h / (HA / 8));
      1: return ((((m_h >> 5) ^ (m_v >> 5)) & 1) == 1) ? 12'hFFF : 12'h000;
      2: return (m_h == m_scroll || m_v == 0 || m_v == VA - 1) ? 12'hFFF : 12'h000;
      default: return {4'((m_h >> 4) & 15), 4'((m_v >> 4) & 15), 4'((m_fcnt >> 4) & 15)};
    endcase
  endfunction

  function automatic vec_t model_out();
    logic de, hs, vs, fs;
    de = enable && m_h < HA && m_v < VA;
    hs = enable && m_h >= HA + HF && m_h < HA + HF + HSW;
    vs = enable && m_v >= VA + VF && m_v < VA + VF + VSW;
    fs = de && m_h == 0 && m_v == 0;
    return {de, hs, vs, fs, 2'(m_mode), 16'(m_fcnt), de ? model_rgb() : 12'h000};
  endfunction

  function automatic vec_t pack_a();
    return {a_de, a_hs, a_vs, a_fs, a_mode, a_fcnt, a_rgb};
  endfunction

  // Inverted-polarity instance, syncs flipped back to active-high sense.
  function automatic vec_t pack_n();
    return {n_de, ~n_hs, ~n_vs, n_fs, n_mode, n_fcnt, n_rgb};
  endfunction

  task automatic observe();
    if (a_fs === 1'b1) begin
      if (scroll_on != 0) begin
        if (col_seen >= 0 && prev_col >= 0) begin
          check_eq("scroll_step", 64'(col_seen), 64'((prev_col + 1) % HA));
          if (prev_col == HA - 1 && col_seen == 0) wraps++;
        end
        if (col_seen >= 0) prev_col = col_seen;
      end
      col_seen = -1;
      obs_row  = 0;
      obs_col  = 0;
    end
    if (a_de === 1'b1) begin
      if (scroll_on != 0 && obs_row == 1 && a_rgb == 12'hFFF) col_seen = obs_col;
      obs_col++;
      if (obs_col == HA) begin
        obs_col = 0;
        obs_row++;
      end
    end
  endtask

  // One clock: push the expectation for the current state, advance the model,
  // then compare the entry that is due at the outputs.
  task automatic tick();
    vec_t e;
    if (reset) begin
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      m_h = 0; m_v = 0; m_mode = 0; m_scroll = 0; m_fcnt = 0;
    end else begin
      exp_q.push_back(model_out());
      if (enable) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin
            m_v      = 0;
            m_mode   = int'(mode_sel);
            m_fcnt   = (m_fcnt + 1) & 16'hFFFF;
            m_scroll = (m_scroll == HA - 1) ? 0 : m_scroll + 1;
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end
    end
    @(posedge clk_dot);
    #1;
    e = exp_q.pop_front();
    check_eq("out", 64'(pack_a()), 64'(e));
    check_eq("out_n", 64'(pack_n()), 64'(e));
    observe();
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (a_fs === 1'b1) return;
    end
    check_eq("fs_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 400; i++) begin
      if (m_h == h && m_v == v) return;
      tick();
    end
    check_eq("pos_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int fc0, de_n, hs_n, vs_n, hs_first;
    reset    = 1'b1;
    enable   = 1'b1;
    mode_sel = 2'd0;

    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_out", 64'(pack_a()), 64'(0));
    check_eq("rst_sync_n", 64'({n_hs, n_vs}), 64'(2'b11));

    // First pixel two clocks after release, then bar 1.
    reset = 1'b0;
    tick();
    tick();
    check_eq("first_px", 64'({a_de, a_fs, a_rgb}), 64'({1'b1, 1'b1, 12'hFFF}));
    tick();
    tick();
    check_eq("bar1", 64'(a_rgb), 64'(12'hFF0));

    // One complete frame measured from frame_start.
    wait_fs();
    fc0 = int'(a_fcnt);
    de_n = 1; hs_n = 0; vs_n = 0; hs_first = -1;
    for (int i = 1; i < HT * VT; i++) begin
      tick();
      de_n += int'(a_de);
      hs_n += int'(a_hs);
      vs_n += int'(a_vs);
      if (a_hs === 1'b1 && hs_first < 0) hs_first = i;
    end
    tick();
    check_eq("fs_period", 64'(a_fs), 64'(1));
    check_eq("fcnt_inc", 64'(a_fcnt), 64'(16'(fc0 + 1)));
    check_eq("de_cycles", 64'(de_n), 64'(HA * VA));
    check_eq("hs_cycles", 64'(hs_n), 64'(HSW * VT));
    check_eq("vs_cycles", 64'(vs_n), 64'(VSW * HT));
    check_eq("hs_offset", 64'(hs_first), 64'(HA + HF));

    // Mode request mid-frame is only taken at the next frame.
    wait_pos(0, 4);
    mode_sel = 2'd3;
    wait_fs();
    check_eq("mode_adopt", 64'(a_mode), 64'(3));
    for (int i = 0; i < 5; i++) tick();
    check_eq("grad_rg", 64'(a_rgb[11:4]), 64'(0));

    // Scroll line across 17 frames.
    mode_sel = 2'd2;
    wait_fs();
    scroll_on = 1; prev_col = -1; col_seen = -1;
    for (int f = 0; f < 17; f++) wait_fs();
    scroll_on = 0;
    check_eq("scroll_wrap", 64'(wraps > 0), 64'(1));

    // Freeze mid-line for 50 clocks.
    wait_pos(5, 1);
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i >= 2) check_eq("dis_quiet", 64'({a_de, a_hs, a_vs, a_rgb}), 64'(0));
    end
    enable = 1'b1;
    tick();
    tick();
    check_eq("resume_de", 64'(a_de), 64'(1));

    // Mid-frame reset.
    wait_pos(3, 6);
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_mid", 64'(pack_a()), 64'(0));
    check_eq("rst_mid_n", 64'({n_de, n_hs, n_vs, n_rgb}), 64'({1'b0, 1'b1, 1'b1, 12'h000}));
    reset = 1'b0;
    wait_fs();
    check_eq("rst_fcnt", 64'(a_fcnt), 64'(0));
    check_eq("rst_mode", 64'(a_mode), 64'(0));
    for (int i = 0; i < 300; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
